copro_io_host: RTL and testbench

//  Hardware master for the coprocessor debug I/O bus: the initiator end of the io_addr/io_control/io_data/io_flags

---
 rtl/copro_io_pkg.sv | 50 +++++
 rtl/copro_io_host_if.sv | 32 +++
 rtl/copro_io_host.sv | 161 ++++++++++++++++
 tb/tb_copro_io_host.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/copro_io_pkg.sv
// Shared types and bit indices for the coprocessor debug I/O host.
package copro_io_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned CTL_W = 6;
  localparam int unsigned FLG_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD        = 3'd0,
    OP_RELEASE     = 3'd1,
    OP_WR_IMEM     = 3'd2,
    OP_WR_DMEM     = 3'd3,
    OP_RD_DMEM     = 3'd4,
    OP_WR_REG      = 3'd5,
    OP_RD_REG      = 3'd6,
    OP_WAIT_EBREAK = 3'd7
  } op_e;

  localparam int unsigned CTL_CORE_RST = 0;
  localparam int unsigned CTL_IMEM_WE  = 1;
  localparam int unsigned CTL_DMEM_WE  = 2;
  localparam int unsigned CTL_DMEM_RE  = 3;
  localparam int unsigned CTL_REG_WE   = 4;
  localparam int unsigned CTL_REG_RE   = 5;

  localparam int unsigned FLG_STALL  = 0;
  localparam int unsigned FLG_EBREAK = 1;

  localparam logic [CTL_W-1:0] CTL_RST_MASK = CTL_W'(1) << CTL_CORE_RST;

  // One-hot strobe for memory/register ops; zero for control and wait ops.
  function automatic logic [CTL_W-1:0] op_strobe(input op_e op);
    logic [CTL_W-1:0] m;
    m = '0;
    case (op)
      OP_WR_IMEM: m[CTL_IMEM_WE] = 1'b1;
      OP_WR_DMEM: m[CTL_DMEM_WE] = 1'b1;
      OP_RD_DMEM: m[CTL_DMEM_RE] = 1'b1;
      OP_WR_REG:  m[CTL_REG_WE]  = 1'b1;
      OP_RD_REG:  m[CTL_REG_RE]  = 1'b1;
      default:    m = '0;
    endcase
    return m;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/copro_io_host_if.sv
// Command/response channel plus the core-facing debug I/O bus of the host.
interface copro_io_host_if
  import copro_io_pkg::*;
#(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 64
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] io_addr;
  logic [CTL_W-1:0]  io_control;
  logic [DATA_W-1:0] io_data_out;
  logic [DATA_W-1:0] io_data_in;
  logic [FLG_W-1:0]  io_flags;

  // master: the host; slave: command source plus core side
  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, io_data_in, io_flags,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, io_addr, io_control, io_data_out
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, io_data_in, io_flags,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, io_addr, io_control, io_data_out
  );
endinterface

// File: rtl/copro_io_host.sv
// Debug I/O bus master: turns one host command at a time into timed strobes
// on the core's io_addr/io_control/io_data bus and returns one response each.
module copro_io_host
  import copro_io_pkg::*;
#(
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned STROBE_CYCLES  = 2,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic            clk,
  input logic            reset,
  copro_io_host_if.master bus
);

  // One shared counter covers strobe width, read latency and the ebreak timeout.
  localparam int unsigned CNT_W = max_u(16, max_u($clog2(TIMEOUT_CYCLES + 1),
                                   max_u($clog2(STROBE_CYCLES + 1), $clog2(READ_LATENCY + 1))));
  localparam bit HAS_TIMEOUT = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_STROBE, S_GAP, S_READ, S_WAIT, S_RESP
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_timeout_q;
  logic [ADDR_W-1:0] io_addr_q;
  logic [DATA_W-1:0] io_data_out_q;
  logic [CTL_W-1:0]  io_control_q;
  logic [DATA_W-1:0] rdata_q;
  logic              timeout_q;

  op_e               op_c;
  logic [CTL_W-1:0]  strobe_c;
  logic              unused_stall;

  assign op_c         = op_e'(bus.cmd_op);
  assign strobe_c     = op_strobe(op_c);
  assign cnt_d        = cnt_q + CNT_W'(1);
  assign unused_stall = bus.io_flags[FLG_STALL];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      io_addr_q     <= '0;
      io_data_out_q <= '0;
      io_control_q  <= CTL_RST_MASK;
      rdata_q       <= '0;
      timeout_q     <= 1'b0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            cmd_ready_q   <= 1'b0;
            io_addr_q     <= bus.cmd_addr;
            io_data_out_q <= bus.cmd_wdata;
            cnt_q         <= '0;
            rdata_q       <= '0;
            timeout_q     <= 1'b0;
            case (op_c)
              OP_HOLD: begin
                io_control_q[CTL_CORE_RST] <= 1'b1;
                state_q                    <= S_RESP;
              end
              OP_RELEASE: begin
                io_control_q[CTL_CORE_RST] <= 1'b0;
                state_q                    <= S_RESP;
              end
              OP_WR_IMEM, OP_WR_DMEM, OP_WR_REG: begin
                io_control_q <= io_control_q | strobe_c;
                state_q      <= S_STROBE;
              end
              OP_RD_DMEM, OP_RD_REG: begin
                io_control_q <= io_control_q | strobe_c;
                state_q      <= S_READ;
              end
              OP_WAIT_EBREAK: begin
                // A core held in reset can never reach ebreak.
                if (io_control_q[CTL_CORE_RST]) begin
                  timeout_q <= 1'b1;
                  state_q   <= S_RESP;
                end else begin
                  state_q <= S_WAIT;
                end
              end
            endcase
          end
        end
        S_STROBE: begin
          if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
            io_control_q <= io_control_q & CTL_RST_MASK;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_GAP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_GAP: begin
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        S_READ: begin
          // Read data is captured on the same edge that drops the enable.
          if (cnt_q == CNT_W'(READ_LATENCY)) begin
            io_control_q <= io_control_q & CTL_RST_MASK;
            rdata_q      <= bus.io_data_in;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WAIT: begin
          if (bus.io_flags[FLG_EBREAK]) begin
            timeout_q <= 1'b0;
            state_q   <= S_RESP;
          end else if (HAS_TIMEOUT && (cnt_d == CNT_W'(TIMEOUT_CYCLES))) begin
            timeout_q <= 1'b1;
            state_q   <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          rsp_valid_q   <= 1'b1;
          rsp_rdata_q   <= rdata_q;
          rsp_timeout_q <= timeout_q;
          cmd_ready_q   <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: begin
          io_control_q <= io_control_q & CTL_RST_MASK;
          cmd_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.io_addr     = io_addr_q;
  assign bus.io_data_out = io_data_out_q;
  assign bus.io_control  = io_control_q;

endmodule

// File: tb/tb_copro_io_host.sv
// Self-checking bench for copro_io_host: directed table, reset corner case,
// then random commands against a cycle-count reference model.
module tb_copro_io_host;
  import copro_io_pkg::*;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 64;
  localparam int S  = 2;
  localparam int L  = 1;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  copro_io_host_if #(.ADDR_W(AW), .DATA_W(DW)) bif();

  copro_io_host #(
    .ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(S), .READ_LATENCY(L), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif.master)
  );

  int checks   = 0;
  int failures = 0;

  logic          ctl0_m;
  logic [DW-1:0] dmem_m [8];
  logic [DW-1:0] reg_m  [8];

  typedef struct {
    op_e           op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            eb_at;
    logic [DW-1:0] core_data;
    logic          exp_to;
    logic [DW-1:0] exp_rdata;
    logic          exp_ctl0;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", what, act, exp);
    end
  endtask

  // Strobe bit positions as listed for io_control.
  function automatic int strobe_pos(input op_e op);
    case (op)
      OP_WR_IMEM: return 1;
      OP_WR_DMEM: return 2;
      OP_RD_DMEM: return 3;
      OP_WR_REG:  return 4;
      OP_RD_REG:  return 5;
      default:    return -1;
    endcase
  endfunction

  // Issue one command and check every cycle from the accept edge until idle again.
  task automatic do_cmd(input string name, input op_e op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int eb_at, input logic [DW-1:0] core_data,
                        input logic exp_to, input logic [DW-1:0] exp_rdata, input logic exp_ctl0);
    int   guard;
    bit   is_wr, is_rd, is_wait;
    int   rsp_c, done_c, k, sp;
    logic [5:0] exp_ctl;
    guard = 0;
    @(negedge clk);
    while (bif.cmd_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      failures++;
      $display("FAIL %s ready-wait expired actual=%b required=1", name, bif.cmd_ready);
    end
    is_wr   = (op == OP_WR_IMEM) || (op == OP_WR_DMEM) || (op == OP_WR_REG);
    is_rd   = (op == OP_RD_DMEM) || (op == OP_RD_REG);
    is_wait = (op == OP_WAIT_EBREAK) && !ctl0_m;
    sp      = strobe_pos(op);
    if (is_wr) begin
      rsp_c = S; done_c = S + 1;
    end else if (is_rd) begin
      rsp_c = L + 2; done_c = rsp_c;
    end else if (is_wait) begin
      k = (eb_at > 0 && (TO == 0 || eb_at <= TO)) ? eb_at : TO;
      rsp_c = k + 1; done_c = rsp_c;
    end else begin
      rsp_c = 1; done_c = 1;
    end
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = op;
    bif.cmd_addr  = addr;
    bif.cmd_wdata = wdata;
    bif.io_flags  = {1'b0, 1'($urandom)};
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    bif.cmd_op    = 3'($urandom);
    bif.cmd_addr  = AW'($urandom);
    bif.cmd_wdata = {$urandom, $urandom};
    for (int c = 0; c <= done_c; c++) begin
      exp_ctl = {5'b0, exp_ctl0};
      if (sp > 0 && ((is_wr && c < S) || (is_rd && c <= L))) exp_ctl[sp] = 1'b1;
      chk($sformatf("%s c%0d io_control", name, c), 64'(bif.io_control), 64'(exp_ctl));
      chk($sformatf("%s c%0d cmd_ready", name, c), 64'(bif.cmd_ready), 64'(c == done_c));
      chk($sformatf("%s c%0d rsp_valid", name, c), 64'(bif.rsp_valid), 64'(c == rsp_c));
      chk($sformatf("%s c%0d rsp_timeout", name, c), 64'(bif.rsp_timeout), 64'((c == rsp_c) && exp_to));
      chk($sformatf("%s c%0d rsp_rdata", name, c), bif.rsp_rdata, (c == rsp_c) ? exp_rdata : 64'd0);
      chk($sformatf("%s c%0d io_addr", name, c), 64'(bif.io_addr), 64'(addr));
      chk($sformatf("%s c%0d io_data_out", name, c), bif.io_data_out, wdata);
      if (c == done_c) break;
      @(negedge clk);
      bif.io_data_in = (is_rd && c == L) ? core_data : {$urandom, $urandom};
      bif.io_flags   = {is_wait && eb_at > 0 && (c + 1) >= eb_at, 1'($urandom)};
      @(posedge clk); #1;
    end
    bif.io_flags = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_e           rop;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdat, core;
    int            reb;
    logic          rto;

    reset          = 1'b1;
    bif.cmd_valid  = 1'b0;
    bif.cmd_op     = '0;
    bif.cmd_addr   = '0;
    bif.cmd_wdata  = '0;
    bif.io_data_in = '0;
    bif.io_flags   = '0;
    ctl0_m         = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dmem_m[i] = {$urandom, $urandom};
      reg_m[i]  = {$urandom, $urandom};
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset: core held, ready, no response pulses.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d io_control", i), 64'(bif.io_control), 64'h01);
      chk($sformatf("idle%0d cmd_ready", i), 64'(bif.cmd_ready), 64'd1);
      chk($sformatf("idle%0d rsp_valid", i), 64'(bif.rsp_valid), 64'd0);
      chk($sformatf("idle%0d io_addr", i), 64'(bif.io_addr), 64'd0);
    end

    vecs.push_back('{OP_WR_DMEM,     15'd0,      64'hA5,                 0,  64'd0,                 1'b0, 64'd0,                 1'b1});
    vecs.push_back('{OP_RD_REG,      15'd5,      64'd0,                  0,  64'hDEAD_BEEF,         1'b0, 64'hDEAD_BEEF,         1'b1});
    vecs.push_back('{OP_WAIT_EBREAK, 15'd0,      64'd0,                  3,  64'd0,                 1'b1, 64'd0,                 1'b1});
    vecs.push_back('{OP_RELEASE,     15'd0,      64'd0,                  0,  64'd0,                 1'b0, 64'd0,                 1'b0});
    vecs.push_back('{OP_WAIT_EBREAK, 15'd0,      64'd0,                  10, 64'd0,                 1'b0, 64'd0,                 1'b0});
    vecs.push_back('{OP_WAIT_EBREAK, 15'd0,      64'd0,                  0,  64'd0,                 1'b1, 64'd0,                 1'b0});
    vecs.push_back('{OP_WAIT_EBREAK, 15'd0,      64'd0,                  16, 64'd0,                 1'b0, 64'd0,                 1'b0});
    vecs.push_back('{OP_WR_IMEM,     15'h7FFF,   64'hFFFF_FFFF_FFFF_FFFF, 0,  64'd0,                 1'b0, 64'd0,                 1'b0});
    vecs.push_back('{OP_RD_DMEM,     15'd3,      64'h1234,               0,  64'h0123_4567_89AB_CDEF, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0});
    vecs.push_back('{OP_WR_REG,      15'd1,      64'h8000_0000_0000_0001, 0,  64'd0,                 1'b0, 64'd0,                 1'b0});
    vecs.push_back('{OP_HOLD,        15'd2,      64'd7,                  0,  64'd0,                 1'b0, 64'd0,                 1'b1});
    vecs.push_back('{OP_RELEASE,     15'd0,      64'd0,                  0,  64'd0,                 1'b0, 64'd0,                 1'b0});

    foreach (vecs[i]) begin
      do_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].eb_at,
             vecs[i].core_data, vecs[i].exp_to, vecs[i].exp_rdata, vecs[i].exp_ctl0);
      ctl0_m = vecs[i].exp_ctl0;
    end

    // Reset during a WR_IMEM strobe aborts it with no response.
    @(negedge clk);
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = OP_WR_IMEM;
    bif.cmd_addr  = 15'h12;
    bif.cmd_wdata = 64'h55;
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    chk("midrst strobe io_control", 64'(bif.io_control), 64'h02);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst io_control", 64'(bif.io_control), 64'h01);
    chk("midrst cmd_ready", 64'(bif.cmd_ready), 64'd1);
    chk("midrst rsp_valid", 64'(bif.rsp_valid), 64'd0);
    chk("midrst io_addr", 64'(bif.io_addr), 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    ctl0_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("postrst%0d rsp_valid", i), 64'(bif.rsp_valid), 64'd0);
      chk($sformatf("postrst%0d io_control", i), 64'(bif.io_control), 64'h01);
    end

    // Random commands against the reference memory/register model.
    for (int n = 0; n < 150; n++) begin
      rop   = op_e'(3'($urandom_range(0, 7)));
      raddr = AW'($urandom_range(0, 7));
      rdat  = {$urandom, $urandom};
      reb   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
      core  = (rop == OP_RD_DMEM) ? dmem_m[raddr[2:0]] :
              (rop == OP_RD_REG)  ? reg_m[raddr[2:0]]  : 64'd0;
      rto   = (rop == OP_WAIT_EBREAK) && (ctl0_m || reb == 0 || reb > TO);
      do_cmd($sformatf("rnd%0d", n), rop, raddr, rdat, reb, core, rto, core,
             (rop == OP_HOLD) ? 1'b1 : (rop == OP_RELEASE) ? 1'b0 : ctl0_m);
      if (rop == OP_HOLD)    ctl0_m = 1'b1;
      if (rop == OP_RELEASE) ctl0_m = 1'b0;
      if (rop == OP_WR_DMEM) dmem_m[raddr[2:0]] = rdat;
      if (rop == OP_WR_REG)  reg_m[raddr[2:0]]  = rdat;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
